// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic {IDLE, SHIFT} piso_state_e;

  function automatic int unsigned cnt_w(input int unsigned data_width);
    return $clog2(data_width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: one bit per enabled cycle, back-to-back
// words without a gap, stall on en=0, synchronous flush.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned SHIFT_LEFT = 1,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  en,
  input  logic                  flush,
  output logic                  serial_out,
  output logic                  ser_we,
  output logic                  busy,
  output logic                  word_done
);

  localparam int unsigned   CW   = cnt_w(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  piso_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         bit_cnt, cnt_d;
  logic                  in_shift, last, step, load;

  always_comb begin
    in_shift   = (state_q == SHIFT);
    last       = (bit_cnt == LAST);
    step       = in_shift & en & ~flush;
    ser_we     = step;
    word_done  = step & last;
    busy       = in_shift;
    // flush gates ready in IDLE too, so a flushed cycle never reports an accept
    load_ready = ~flush & (~in_shift | (step & last));
    load       = load_valid & load_ready;
    serial_out = in_shift & ((SHIFT_LEFT != 0) ? shift_q[DATA_WIDTH-1] : shift_q[0]);

    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = bit_cnt;
    if (flush) begin
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
    end else if (load) begin
      state_d = SHIFT;
      shift_d = load_data;
      cnt_d   = '0;
    end else if (step) begin
      if (SHIFT_LEFT != 0) shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
      else                 shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
      if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = bit_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus,
// each looped back into a behavioural shift-register receiver.
module tb_piso_serializer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         en = 1'b0;
  logic         flush = 1'b0;

  logic ready_m, ser_m, we_m, busy_m, done_m;
  logic ready_l, ser_l, we_l, busy_l, done_l;

  always #5 clk = ~clk;

  piso_serializer #(.SHIFT_LEFT(1), .DATA_WIDTH(W)) dut_m (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready_m),
    .load_data(load_data), .en(en), .flush(flush), .serial_out(ser_m),
    .ser_we(we_m), .busy(busy_m), .word_done(done_m)
  );

  piso_serializer #(.SHIFT_LEFT(0), .DATA_WIDTH(W)) dut_l (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready_l),
    .load_data(load_data), .en(en), .flush(flush), .serial_out(ser_l),
    .ser_we(we_l), .busy(busy_l), .word_done(done_l)
  );

  // Loopback receivers: left-shifting for MSB-first, right-shifting for LSB-first
  logic [W-1:0] rx_m, rx_l;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= '0;
      rx_l <= '0;
    end else begin
      if (we_m) rx_m <= {rx_m[W-2:0], ser_m};
      if (we_l) rx_l <= {ser_l, rx_l[W-1:1]};
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model: the word in flight and how many of its bits have gone out
  bit           m_active = 1'b0;
  logic [W-1:0] m_word = '0;
  int           m_sent = 0;
  bit           rx_due = 1'b0;
  logic [W-1:0] rx_word = '0;

  int n_we, n_done, n_acc, cyc, first_done_cyc, last_done_cyc;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         e;
    logic         f;
    logic         r;
    logic         b;
    logic         w;
    logic         sm;
    logic         sl;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_sent   = 0;
    rx_due   = 1'b0;
  endtask

  task automatic clr_counts();
    n_we = 0; n_done = 0; n_acc = 0; cyc = 0;
    first_done_cyc = -1; last_done_cyc = -1;
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic e, input logic f);
    logic x_we, x_done, x_ready, x_sm, x_sl;
    @(negedge clk);
    load_valid = v; load_data = d; en = e; flush = f;
    #1;
    x_we    = m_active && e && !f;
    x_done  = x_we && (m_sent == W - 1);
    x_ready = !f && (!m_active || x_done);
    x_sm    = m_active ? m_word[W-1-m_sent] : 1'b0;
    x_sl    = m_active ? m_word[m_sent] : 1'b0;
    chk("busy_m",  32'(busy_m),  32'(m_active));
    chk("busy_l",  32'(busy_l),  32'(m_active));
    chk("we_m",    32'(we_m),    32'(x_we));
    chk("we_l",    32'(we_l),    32'(x_we));
    chk("done_m",  32'(done_m),  32'(x_done));
    chk("done_l",  32'(done_l),  32'(x_done));
    chk("ready_m", 32'(ready_m), 32'(x_ready));
    chk("ready_l", 32'(ready_l), 32'(x_ready));
    chk("ser_m",   32'(ser_m),   32'(x_sm));
    chk("ser_l",   32'(ser_l),   32'(x_sl));
    if (rx_due) begin
      chk("rx_m", rx_m, rx_word);
      chk("rx_l", rx_l, rx_word);
      rx_due = 1'b0;
    end
    cyc++;
    if (we_m) n_we++;
    if (done_m) begin
      n_done++;
      if (first_done_cyc < 0) first_done_cyc = cyc;
      last_done_cyc = cyc;
    end
    if (v && ready_m) n_acc++;
    @(posedge clk);
    if (f) begin
      m_active = 1'b0;
      m_sent   = 0;
    end else if (v && x_ready) begin
      if (x_done) begin rx_due = 1'b1; rx_word = m_word; end
      m_word   = d;
      m_sent   = 0;
      m_active = 1'b1;
    end else if (x_we) begin
      if (x_done) begin
        rx_due   = 1'b1;
        rx_word  = m_word;
        m_active = 1'b0;
        m_sent   = 0;
      end else begin
        m_sent++;
      end
    end
  endtask

  task automatic idle_step();
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    tbl[0] = '{v:1'b0, d:32'h0,        e:1'b1, f:1'b0, r:1'b1, b:1'b0, w:1'b0, sm:1'b0, sl:1'b0};
    tbl[1] = '{v:1'b1, d:32'hA5A50F0C, e:1'b0, f:1'b0, r:1'b1, b:1'b0, w:1'b0, sm:1'b0, sl:1'b0};
    tbl[2] = '{v:1'b0, d:32'h0,        e:1'b1, f:1'b0, r:1'b0, b:1'b1, w:1'b1, sm:1'b1, sl:1'b0};
    tbl[3] = '{v:1'b0, d:32'h0,        e:1'b1, f:1'b0, r:1'b0, b:1'b1, w:1'b1, sm:1'b0, sl:1'b0};
    tbl[4] = '{v:1'b0, d:32'h0,        e:1'b0, f:1'b0, r:1'b0, b:1'b1, w:1'b0, sm:1'b1, sl:1'b1};
    tbl[5] = '{v:1'b1, d:32'hFFFFFFFF, e:1'b1, f:1'b1, r:1'b0, b:1'b1, w:1'b0, sm:1'b1, sl:1'b1};
    tbl[6] = '{v:1'b0, d:32'h0,        e:1'b1, f:1'b0, r:1'b1, b:1'b0, w:1'b0, sm:1'b0, sl:1'b0};

    clr_counts();
    #3;
    chk("rst_busy",  32'(busy_m),  32'd0);
    chk("rst_we",    32'(we_m),    32'd0);
    chk("rst_done",  32'(done_m),  32'd0);
    chk("rst_ser",   32'(ser_m),   32'd0);
    chk("rst_ready", 32'(ready_m), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Handshake, first-bit latency, stall in IDLE and SHIFT, flush vs load
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].f);
      chk("tbl_ready", 32'(ready_m), 32'(tbl[i].r));
      chk("tbl_busy",  32'(busy_m),  32'(tbl[i].b));
      chk("tbl_we",    32'(we_m),    32'(tbl[i].w));
      chk("tbl_ser_m", 32'(ser_m),   32'(tbl[i].sm));
      chk("tbl_ser_l", 32'(ser_l),   32'(tbl[i].sl));
    end

    // Single word
    clr_counts();
    step(1'b1, 32'hA5A50F0F, 1'b1, 1'b0);
    for (int k = 0; k < 32; k++) idle_step();
    chk("single_we", n_we, 32'd32);
    chk("single_done_n", n_done, 32'd1);
    chk("single_done_at", last_done_cyc, 32'd33);
    idle_step();
    chk("single_idle", 32'(busy_m), 32'd0);

    // Back-to-back words
    clr_counts();
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    for (int k = 0; k < 64; k++) step(k < 32, 32'h12345678, 1'b1, 1'b0);
    chk("b2b_we", n_we, 32'd64);
    chk("b2b_done_n", n_done, 32'd2);
    chk("b2b_acc", n_acc, 32'd2);
    chk("b2b_gap", last_done_cyc - first_done_cyc, 32'd32);
    idle_step();

    // Stall for 5 cycles after bit 10
    clr_counts();
    step(1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
    for (int k = 0; k < 37; k++) step(1'b0, '0, !(k >= 10 && k < 15), 1'b0);
    chk("stall_we", n_we, 32'd32);
    chk("stall_done_at", last_done_cyc, 32'd38);
    idle_step();

    // LSB-first single set bit (checked on dut_l by the model)
    clr_counts();
    step(1'b1, 32'h00000001, 1'b1, 1'b0);
    for (int k = 0; k < 32; k++) idle_step();
    chk("lsb_we", n_we, 32'd32);
    idle_step();

    // Flush at bit 16 with a competing load
    step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) idle_step();
    step(1'b1, 32'h5555AAAA, 1'b1, 1'b1);
    chk("flush_ready", 32'(ready_m), 32'd0);
    chk("flush_we", 32'(we_m), 32'd0);
    idle_step();
    chk("flush_idle", 32'(busy_m), 32'd0);
    chk("flush_ready_after", 32'(ready_m), 32'd1);
    clr_counts();
    step(1'b1, 32'h3C5A9617, 1'b1, 1'b0);
    for (int k = 0; k < 32; k++) idle_step();
    idle_step();
    chk("flush_next_done", n_done, 32'd1);

    // Asynchronous reset mid-word
    step(1'b1, 32'hABCD1234, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) idle_step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ser_m", 32'(ser_m),  32'd0);
    chk("arst_ser_l", 32'(ser_l),  32'd0);
    chk("arst_we",    32'(we_m),   32'd0);
    chk("arst_busy",  32'(busy_m), 32'd0);
    chk("arst_done",  32'(done_m), 32'd0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    clr_counts();
    step(1'b1, 32'h00000000, 1'b1, 1'b0);
    for (int k = 0; k < 32; k++) idle_step();
    idle_step();
    chk("arst_we_n", n_we, 32'd32);
    chk("arst_done_n", n_done, 32'd1);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 8,
           $urandom_range(0, 29) == 0);
    end
    for (int k = 0; k < 40; k++) idle_step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
